// File: rtl/multi_dataflow_package.sv
// Shared types and defaults for the dataflow engine control stage.
//   ENGINE_CNT_W / ENGINE_DIM_W : default counter and frame-dimension widths
//   ST_*                        : FSM state encodings (legacy localparam form)
//   engine_state_t              : the same encodings as an enum, for integration code
//   ctrl_engine_t               : controller-side bundle of the job request fields
package multi_dataflow_package;

    localparam int unsigned ENGINE_CNT_W = 32;
    localparam int unsigned ENGINE_DIM_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        COMPUTE = ST_COMPUTE,
        DRAIN   = ST_DRAIN,
        DONE    = ST_DONE
    } engine_state_t;

    typedef struct packed {
        logic        trigger;
        logic        clear;
        logic [31:0] width;
        logic [31:0] height;
    } ctrl_engine_t;

endpackage

// File: rtl/multi_dataflow_job_counter.sv
// Job-length latch and output counter for the dataflow engine.
//   clear_i         : soft clear, zeroes count and total
//   load_i          : latch total = width*height; clears the count unless the product is zero
//   width_i/height_i: frame dimensions (already truncated to DIM_W)
//   inc_i           : one output produced
//   cnt_o           : outputs counted in the current job
//   zero_o          : current width_i*height_i is zero (combinational)
//   last_o          : inc_i is the increment that makes the count reach total
module multi_dataflow_job_counter
    import multi_dataflow_package::*;
#(
    parameter int unsigned CNT_W = ENGINE_CNT_W,
    parameter int unsigned DIM_W = ENGINE_DIM_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             last_o
);

    logic [2*DIM_W-1:0] width_ext;
    logic [2*DIM_W-1:0] height_ext;
    logic [2*DIM_W-1:0] prod;
    logic [CNT_W-1:0]   total_new;
    logic [CNT_W-1:0]   total_d, total_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    assign width_ext  = {{DIM_W{1'b0}}, width_i};
    assign height_ext = {{DIM_W{1'b0}}, height_i};
    assign prod       = width_ext * height_ext;
    assign total_new  = CNT_W'(prod);
    assign zero_o     = (prod == '0);
    assign last_o     = inc_i && ((cnt_q + CNT_W'(1)) == total_q);
    assign cnt_o      = cnt_q;

    always_comb begin
        total_d = total_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            total_d = '0;
            cnt_d   = '0;
        end else if (load_i) begin
            total_d = total_new;
            // A zero-length job never reaches START, so the previous count is kept.
            if (!zero_o) cnt_d = '0;
        end else if (inc_i && (cnt_q != total_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
            cnt_q   <= '0;
        end else begin
            total_q <= total_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dataflow_engine_fsm.sv
// Job sequencer between the HWPE control slave and multi_dataflow_kernel_adapter.
// Inputs : clk_i, rst_ni, clear_i, trigger_i, width_i, height_i,
//          kernel_done_i/ready_i/idle_i (adapter flags), out_stream_done_i
// Outputs: kernel_start_o, in_stream_start_o, out_stream_start_o (START pulses),
//          cnt_out_o, busy_o, done_o, err_zero_o, err_spurious_o
//
// state   | meaning
// IDLE    | waiting for trigger_i
// START   | one-cycle start pulse to kernel and both streamers
// COMPUTE | counting kernel_done_i until the job total is reached
// DRAIN   | waiting for the output streamer to flush
// DONE    | one-cycle completion pulse
module multi_dataflow_engine_fsm
    import multi_dataflow_package::*;
#(
    parameter int unsigned CNT_W = ENGINE_CNT_W,
    parameter int unsigned DIM_W = ENGINE_DIM_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             trigger_i,
    input  logic [31:0]      width_i,
    input  logic [31:0]      height_i,
    input  logic             kernel_done_i,
    input  logic             kernel_ready_i,
    input  logic             kernel_idle_i,
    input  logic             out_stream_done_i,
    output logic             kernel_start_o,
    output logic             in_stream_start_o,
    output logic             out_stream_start_o,
    output logic [CNT_W-1:0] cnt_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_zero_o,
    output logic             err_spurious_o
);

    logic [2:0] state_d, state_q;
    logic       err_zero_d, err_zero_q;
    logic       err_spur_d, err_spur_q;
    logic       load, inc, zero, last;

    // Ready/idle are observation-only; upper dimension bits are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{kernel_ready_i, kernel_idle_i,
                             width_i[31:DIM_W], height_i[31:DIM_W]};

    multi_dataflow_job_counter #(
        .CNT_W (CNT_W),
        .DIM_W (DIM_W)
    ) u_job_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .load_i   (load),
        .width_i  (width_i[DIM_W-1:0]),
        .height_i (height_i[DIM_W-1:0]),
        .inc_i    (inc),
        .cnt_o    (cnt_out_o),
        .zero_o   (zero),
        .last_o   (last)
    );

    always_comb begin
        state_d    = state_q;
        err_zero_d = err_zero_q;
        err_spur_d = err_spur_q;
        load       = 1'b0;
        inc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger_i) begin
                    load       = 1'b1;
                    err_zero_d = zero;
                    err_spur_d = 1'b0;
                    state_d    = zero ? ST_DONE : ST_START;
                end
            end
            ST_START:   state_d = ST_COMPUTE;
            ST_COMPUTE: begin
                inc = kernel_done_i;
                // last already covers the increment that reaches total.
                if (last) state_d = ST_DRAIN;
            end
            ST_DRAIN:   if (out_stream_done_i) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (kernel_done_i &&
            ((state_q == ST_IDLE) || (state_q == ST_DRAIN) || (state_q == ST_DONE))) begin
            err_spur_d = 1'b1;
        end

        if (clear_i) begin
            state_d    = ST_IDLE;
            err_zero_d = 1'b0;
            err_spur_d = 1'b0;
            load       = 1'b0;
            inc        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            err_zero_q <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_zero_q <= err_zero_d;
            err_spur_q <= err_spur_d;
        end
    end

    assign kernel_start_o     = (state_q == ST_START);
    assign in_stream_start_o  = (state_q == ST_START);
    assign out_stream_start_o = (state_q == ST_START);
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);
    assign err_zero_o         = err_zero_q;
    assign err_spurious_o     = err_spur_q;

endmodule

// File: tb/tb_multi_dataflow_engine_fsm.sv
// Randomized scoreboard bench for multi_dataflow_engine_fsm.
module tb_multi_dataflow_engine_fsm;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i, trigger_i;
    logic [31:0] width_i, height_i;
    logic        kernel_done_i, kernel_ready_i, kernel_idle_i, out_stream_done_i;
    logic        kernel_start_o, in_stream_start_o, out_stream_start_o;
    logic [31:0] cnt_out_o;
    logic        busy_o, done_o, err_zero_o, err_spurious_o;

    multi_dataflow_engine_fsm dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .trigger_i          (trigger_i),
        .width_i            (width_i),
        .height_i           (height_i),
        .kernel_done_i      (kernel_done_i),
        .kernel_ready_i     (kernel_ready_i),
        .kernel_idle_i      (kernel_idle_i),
        .out_stream_done_i  (out_stream_done_i),
        .kernel_start_o     (kernel_start_o),
        .in_stream_start_o  (in_stream_start_o),
        .out_stream_start_o (out_stream_start_o),
        .cnt_out_o          (cnt_out_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_zero_o         (err_zero_o),
        .err_spurious_o     (err_spurious_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        bit          ez;
        bit          es;
        int unsigned starts;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned n_start = 0;
    int unsigned prev_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Monitor: counts start pulses and scores every done_o against the queue.
    initial forever begin
        exp_t e;
        @(posedge clk_i);
        #2;
        if (rst_ni) begin
            if (kernel_start_o) n_start++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_cnt", cnt_out_o, e.cnt);
                    chk("done_err_zero", err_zero_o, e.ez);
                    chk("done_err_spur", err_spurious_o, e.es);
                    chk("done_busy", busy_o, 1);
                    chk("start_pulses", n_start, e.starts);
                end
                n_start = 0;
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk_i);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // mode: 0 normal, 1 soft clear after clr_at outputs, 2 async reset in DRAIN
    task automatic run_job(input logic [31:0] w, input logic [31:0] h, input bit extra,
                           input int mode, input int clr_at, input int max_gap);
        int unsigned tot, sumg, dd, c;
        int unsigned g[$];
        exp_t e;
        tot  = (w % 32'd65536) * (h % 32'd65536);
        dd   = $urandom_range(0, 4);
        sumg = 0;
        for (int k = 0; k < int'(tot); k++) begin
            g.push_back($urandom_range(0, max_gap));
            sumg += g[k];
        end
        c = cyc;
        width_i = w; height_i = h; trigger_i = 1'b1;
        if (mode == 0) begin
            if (tot == 0) begin
                e.cyc = c + 1; e.cnt = prev_cnt; e.ez = 1; e.es = 0; e.starts = 0;
            end else begin
                e.cyc = c + 3 + sumg + tot + dd; e.cnt = tot; e.ez = 0; e.es = extra; e.starts = 1;
            end
            exp_q.push_back(e);
        end
        step();
        trigger_i = 1'b0; width_i = $urandom; height_i = $urandom;
        if (tot == 0) begin
            chk("zero_no_start", {kernel_start_o, in_stream_start_o, out_stream_start_o}, 0);
            chk("zero_err", err_zero_o, 1);
            step();
            chk("zero_busy_after", busy_o, 0);
            return;
        end
        chk("start_pulses_t1", {kernel_start_o, in_stream_start_o, out_stream_start_o}, 3'b111);
        chk("start_cnt", cnt_out_o, 0);
        chk("start_busy", busy_o, 1);
        step();
        chk("start_single", kernel_start_o, 0);
        for (int k = 0; k < int'(tot); k++) begin
            if (mode == 1 && clr_at == k) begin
                clear_i = 1'b1;
                step();
                clear_i = 1'b0;
                chk("clr_busy", busy_o, 0);
                chk("clr_cnt", cnt_out_o, 0);
                chk("clr_errs", {err_zero_o, err_spurious_o}, 0);
                n_start = 0; prev_cnt = 0;
                repeat (3) step();
                return;
            end
            for (int j = 0; j < int'(g[k]); j++) begin
                trigger_i = 1'($urandom_range(0, 1));
                kernel_ready_i = 1'($urandom_range(0, 1));
                kernel_idle_i = 1'($urandom_range(0, 1));
                step();
                chk("cnt_mid", cnt_out_o, k);
            end
            trigger_i = 1'b0;
            kernel_done_i = 1'b1;
            step();
            kernel_done_i = 1'b0;
        end
        chk("drain_cnt", cnt_out_o, tot);
        chk("drain_busy", busy_o, 1);
        chk("drain_no_done", done_o, 0);
        if (mode == 2) begin
            out_stream_done_i = 1'b1;
            #1 rst_ni = 1'b0;
            #1;
            chk("rst_outs", {kernel_start_o, in_stream_start_o, out_stream_start_o,
                             busy_o, done_o, err_zero_o, err_spurious_o}, 0);
            chk("rst_cnt", cnt_out_o, 0);
            step();
            out_stream_done_i = 1'b0;
            rst_ni = 1'b1;
            n_start = 0; prev_cnt = 0;
            repeat (3) step();
            return;
        end
        if (extra) kernel_done_i = 1'b1;
        for (int j = 0; j < int'(dd); j++) begin
            step();
            kernel_done_i = 1'b0;
        end
        out_stream_done_i = 1'b1;
        step();
        kernel_done_i = 1'b0; out_stream_done_i = 1'b0;
        step();
        chk("after_busy", busy_o, 0);
        chk("after_cnt_hold", cnt_out_o, tot);
        prev_cnt = tot;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 0; trigger_i = 0; width_i = 0; height_i = 0;
        kernel_done_i = 0; kernel_ready_i = 0; kernel_idle_i = 0; out_stream_done_i = 0;
        repeat (3) step();
        chk("rst_outs", {kernel_start_o, in_stream_start_o, out_stream_start_o,
                         busy_o, done_o, err_zero_o, err_spurious_o}, 0);
        chk("rst_cnt", cnt_out_o, 0);
        rst_ni = 1'b1;
        step();

        run_job(32'd0, 32'd7, 0, 0, -1, 0);
        run_job(32'd4, 32'd2, 0, 0, -1, 3);
        run_job(32'd3, 32'd1, 1, 0, -1, 0);
        run_job(32'h0001_0002, 32'd2, 0, 0, -1, 2);

        kernel_done_i = 1'b1;
        step();
        kernel_done_i = 1'b0;
        chk("idle_spur", err_spurious_o, 1);
        chk("idle_spur_cnt", cnt_out_o, prev_cnt);
        step();

        run_job(32'd0, 32'd5, 0, 0, -1, 0);
        run_job(32'd4, 32'd2, 0, 1, 2, 3);
        run_job(32'd2, 32'd3, 0, 0, -1, 2);
        run_job(32'd2, 32'd2, 0, 2, -1, 2);
        run_job(32'd1, 32'd1, 0, 0, -1, 1);

        for (int i = 0; i < 15; i++) begin
            run_job($urandom_range(0, 4) | ($urandom_range(0, 1) << 20), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 0, -1, 3);
        end

        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
